// File: rtl/jtag_multi_dr.sv
// JTAG user data-register bank: NUM_CH capture/shift channels plus IEEE bypass bit.
// Optional even-parity check over the shifted frame when JTAG_MULTI_DR_PARITY_EN is defined.
module jtag_multi_dr #(
    parameter int NUM_CH    = 4,
    parameter int DR_W      = 32,
    parameter int CH_W      = 2,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 7
) (
    input  logic                   clockDR,
    input  logic                   trst_n,
    input  logic                   capture_dr,
    input  logic                   shift_dr,
    input  logic                   bypass_sel,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic                   tdi,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    output logic                   tdo,
    output logic [DR_W-1:0]        dr_data,
    output logic [CNT_W-1:0]       bit_cnt,
    output logic                   frame_ok,
    output logic                   len_err
`ifdef JTAG_MULTI_DR_PARITY_EN
    ,
    output logic                   par_ok
`endif
);

    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_W + 1);

    logic [DR_W-1:0]  sr_q, sr_d;
    logic             byp_q, byp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lerr_q, lerr_d;
    logic             bypass_mode;
    logic [DR_W-1:0]  cap_sel;
`ifdef JTAG_MULTI_DR_PARITY_EN
    logic             par_q, par_d;
`endif

    // Out-of-range channels fall back to bypass, so the slice mux never indexes past cap_data.
    assign bypass_mode = bypass_sel || ({1'b0, ch_sel} >= NUM_CH_L);

    always_comb begin
        cap_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_W'(k))
                cap_sel = cap_data[k*DR_W +: DR_W];
        end
    end

    always_comb begin
        sr_d   = sr_q;
        byp_d  = byp_q;
        cnt_d  = cnt_q;
        lerr_d = lerr_q;
`ifdef JTAG_MULTI_DR_PARITY_EN
        par_d  = par_q;
`endif
        if (capture_dr) begin
            cnt_d  = '0;
            lerr_d = 1'b0;
`ifdef JTAG_MULTI_DR_PARITY_EN
            par_d  = 1'b0;
`endif
            if (bypass_mode)
                byp_d = 1'b0;
            else
                sr_d = cap_sel;
        end else if (shift_dr) begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_FULL)
                lerr_d = 1'b1;
            if (bypass_mode) begin
                byp_d = tdi;
            end else begin
                if (LSB_FIRST != 0)
                    sr_d = {tdi, sr_q[DR_W-1:1]};
                else
                    sr_d = {sr_q[DR_W-2:0], tdi};
`ifdef JTAG_MULTI_DR_PARITY_EN
                par_d = par_q ^ tdi;
`endif
            end
        end
    end

    always_ff @(posedge clockDR or negedge trst_n) begin
        if (!trst_n) begin
            sr_q   <= '0;
            byp_q  <= 1'b0;
            cnt_q  <= '0;
            lerr_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            byp_q  <= byp_d;
            cnt_q  <= cnt_d;
            lerr_q <= lerr_d;
        end
    end

`ifdef JTAG_MULTI_DR_PARITY_EN
    always_ff @(posedge clockDR or negedge trst_n) begin
        if (!trst_n)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end

    assign par_ok = frame_ok && !par_q;
`endif

    assign tdo      = bypass_mode ? byp_q : ((LSB_FIRST != 0) ? sr_q[0] : sr_q[DR_W-1]);
    assign dr_data  = sr_q;
    assign bit_cnt  = cnt_q;
    assign frame_ok = (cnt_q == CNT_FULL);
    assign len_err  = lerr_q;

endmodule
